// File: rtl/pci_pkg.sv
// pci_pkg: shared PCI constants, arbiter defaults and state type.
package pci_pkg;
    localparam int NUM_AGENTS_DEF = 4;
    localparam int MAX_AGENTS = 8;
    localparam logic [MAX_AGENTS-1:0] NO_GRANT = '1;
    localparam logic [3:0] CMD_INT_ACK   = 4'b0000;
    localparam logic [3:0] CMD_IO_READ   = 4'b0010;
    localparam logic [3:0] CMD_IO_WRITE  = 4'b0011;
    localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
    localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;
    localparam logic [3:0] CMD_CFG_READ  = 4'b1010;
    localparam logic [3:0] CMD_CFG_WRITE = 4'b1011;
    typedef enum logic {SWITCH, GRANT} arb_state_t;
endpackage

// File: rtl/pci_rr_select.sv
// pci_rr_select: round-robin winner search starting after owner, owner last.
module pci_rr_select #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] owner,
    output logic [W-1:0] winner,
    output logic         any_req
);
    logic [W-1:0] idx;
    assign any_req = |req;
    // Scan farthest-first so the nearest requester after owner wins.
    always_comb begin
        winner = owner;
        idx = owner;
        for (int k = N; k >= 1; k--) begin
            idx = W'((int'(owner) + k) % N);
            winner = req[idx] ? idx : winner;
        end
    end
endmodule

// File: rtl/pci_bus_arbiter.sv
// pci_bus_arbiter: round-robin PCI arbiter with parking and one-cycle grant turnaround.
module pci_bus_arbiter
    import pci_pkg::*;
#(
    parameter int NUM_AGENTS = NUM_AGENTS_DEF,
    parameter int PARK_AGENT = 0,
    localparam int W = $clog2(NUM_AGENTS)
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  FRAMEn,
    input  logic                  IRDYn,
    input  logic [NUM_AGENTS-1:0] REQn,
    output logic [NUM_AGENTS-1:0] GNTn
);
    logic [NUM_AGENTS-1:0] req, owner_hot;
    logic [W-1:0] owner, winner;
    logic any_req, started, bus_idle, other_req, leave;
    arb_state_t state;

    assign req = ~REQn;
    assign bus_idle = FRAMEn & IRDYn;
    assign owner_hot = NUM_AGENTS'(1) << owner;
    assign other_req = |(req & ~owner_hot);
    // Owner keeps the bus until it has started or dropped its request.
    assign leave = other_req && (!req[owner] || started);

    pci_rr_select #(.N(NUM_AGENTS)) u_sel (
        .req(req),
        .owner(owner),
        .winner(winner),
        .any_req(any_req)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= SWITCH;
            owner <= W'(PARK_AGENT);
            started <= 1'b0;
            GNTn <= NO_GRANT[NUM_AGENTS-1:0];
        end else if (state == SWITCH) begin
            state <= GRANT;
            owner <= any_req ? winner : owner;
            started <= 1'b0;
            GNTn <= ~(NUM_AGENTS'(1) << (any_req ? winner : owner));
        end else begin
            state <= leave ? SWITCH : GRANT;
            started <= started | (~FRAMEn & ~bus_idle);
            GNTn <= leave ? NO_GRANT[NUM_AGENTS-1:0] : GNTn;
        end
    end
endmodule

// File: tb/tb_pci_bus_arbiter.sv
// tb_pci_bus_arbiter: scoreboard bench against a tenure-level arbiter model.
module tb_pci_bus_arbiter;
    localparam int N = 4;
    localparam int PARK = 0;

    logic CLK = 0, RESET = 1, FRAMEn = 1, IRDYn = 1;
    logic [N-1:0] REQn = '1;
    logic [N-1:0] GNTn;

    int n_checks = 0, n_fail = 0;
    logic [N-1:0] exp_q[$];

    bit m_granted = 0, m_started = 0;
    int m_owner = PARK;
    logic [N-1:0] m_req;

    always #5 CLK = ~CLK;

    pci_bus_arbiter #(.NUM_AGENTS(N), .PARK_AGENT(PARK)) dut (
        .CLK(CLK), .RESET(RESET), .FRAMEn(FRAMEn), .IRDYn(IRDYn),
        .REQn(REQn), .GNTn(GNTn)
    );

    // Model: tracks tenure (granted/owner/started) and emits the grant seen after each edge.
    always @(posedge CLK) begin
        bit others;
        int w;
        m_req = ~REQn;
        if (RESET) begin
            m_granted = 0;
            m_owner = PARK;
            m_started = 0;
        end else if (!m_granted) begin
            w = m_owner;
            for (int d = N; d >= 1; d--)
                if (m_req[(m_owner + d) % N] === 1'b1) w = (m_owner + d) % N;
            m_owner = w;
            m_granted = 1;
            m_started = 0;
        end else begin
            others = 0;
            for (int j = 0; j < N; j++)
                if (j != m_owner && m_req[j] === 1'b1) others = 1;
            if (others && (m_req[m_owner] !== 1'b1 || m_started)) m_granted = 0;
            else if (!FRAMEn) m_started = 1;
        end
        exp_q.push_back(m_granted ? ~(4'b0001 << m_owner) : 4'b1111);
    end

    always @(negedge CLK) begin
        logic [N-1:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: GNTn=%b with no expected entry", GNTn);
        end else begin
            e = exp_q.pop_front();
            if (GNTn !== e) begin
                n_fail++;
                $display("FAIL gnt @%0t: GNTn=%b expected %b", $time, GNTn, e);
            end
        end
        n_checks++;
        if ($countones(~GNTn) > 1) begin
            n_fail++;
            $display("FAIL one_grant @%0t: GNTn=%b has %0d grants, expected <=1", $time, GNTn, $countones(~GNTn));
        end
    end

    task automatic drive(input logic [N-1:0] r, input logic f, input logic rst, input int n);
        repeat (n) begin
            @(negedge CLK);
            REQn = r;
            FRAMEn = f;
            RESET = rst;
        end
    endtask

    initial begin
        drive(4'b1111, 1, 1, 3);
        drive(4'b1111, 1, 0, 6);
        drive(4'b1101, 1, 0, 4);
        drive(4'b1100, 1, 0, 6);
        drive(4'b1011, 1, 0, 4);
        drive(4'b0011, 0, 0, 6);
        drive(4'b1011, 1, 0, 4);
        drive(4'b1111, 1, 1, 2);
        drive(4'b1111, 1, 0, 5);
        repeat (40) begin
            @(negedge CLK);
            REQn = 4'b0000;
            FRAMEn = (GNTn == 4'b1111);
        end
        repeat (3000) begin
            @(negedge CLK);
            REQn = N'($urandom);
            FRAMEn = ($urandom_range(0, 3) != 0);
            IRDYn = $urandom_range(0, 1) == 1;
            RESET = ($urandom_range(0, 199) == 0);
        end
        drive(4'b1111, 1, 0, 3);
        @(negedge CLK);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
